// File: rtl/teclado_scanner_if.sv
// Keypad-side bundle: row sense in, column drive, accepted key code and detect strobe out.
// The scanner takes the master view; the keypad/consumer side takes the slave view.
interface teclado_scanner_if;
    logic [3:0] filas_i;
    logic [3:0] columnas_o;
    logic [3:0] teclado_o;
    logic       key_detect_o;

    modport master (input filas_i, output columnas_o, teclado_o, key_detect_o);
    modport slave  (output filas_i, input columnas_o, teclado_o, key_detect_o);
endinterface

// File: rtl/teclado_scanner.sv
// 4x4 keypad scanner with debouncer; TECLADO_AUTOREPEAT_EN adds held-key auto-repeat pulses.
// Pulse <= (4+DEBOUNCE_SAMPLES)*SCAN_TICKS+3 cycles after a stable press; no backpressure.
module teclado_scanner #(
    parameter int SCAN_TICKS       = 1000,
    parameter int DEBOUNCE_SAMPLES = 8,
    parameter int REPEAT_SAMPLES   = 400
) (
    input logic               clk_i,
    input logic               reset_i,
    teclado_scanner_if.master bus
);
    if (SCAN_TICKS < 4 || DEBOUNCE_SAMPLES < 2 || REPEAT_SAMPLES < 1) begin : g_param_check
        $error("teclado_scanner: illegal parameter value");
    end

    localparam int TW = $clog2(SCAN_TICKS);
    localparam int DW = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_SAMPLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    sync_q, filas_s;
    logic [TW-1:0] tick_cnt;
    logic [DW-1:0] stab_cnt;
    logic [3:0]    pat_q;
    logic [1:0]    row_q, col_q;
    logic [3:0]    teclado_q;
    logic          key_detect_q;
    logic          sample, any_low, match;
    logic          capture, advance, accept, repeat_hit, pulse;

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'h0;
        unique case ({row, col})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  4'hF: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Rows idle high, so the synchronizer resets to all-released.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync_q  <= 4'hF;
            filas_s <= 4'hF;
        end else begin
            sync_q  <= bus.filas_i;
            filas_s <= sync_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i)                 tick_cnt <= '0;
        else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
        else                          tick_cnt <= tick_cnt + 1'b1;
    end

    assign sample  = (tick_cnt == TICK_LAST);
    assign any_low = (filas_s != 4'hF);
    assign match   = (filas_s == pat_q);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state <= SCAN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (sample) begin
            unique case (state)
                SCAN:     if (any_low) state_nxt = DEBOUNCE;
                DEBOUNCE: if (!match) state_nxt = SCAN;
                          else if (stab_cnt == DEB_LAST) state_nxt = PRESSED;
                PRESSED:  if (!any_low) state_nxt = RELEASE;
                RELEASE:  if (any_low) state_nxt = PRESSED;
                          else if (stab_cnt == DEB_LAST) state_nxt = SCAN;
            endcase
        end
    end

    always_comb begin
        capture = sample && (state == SCAN) && any_low;
        accept  = sample && (state == DEBOUNCE) && match && (stab_cnt == DEB_LAST);
        advance = sample && (((state == SCAN) && !any_low) ||
                             ((state == DEBOUNCE) && !match) ||
                             ((state == RELEASE) && !any_low && (stab_cnt == DEB_LAST)));
        pulse   = accept || repeat_hit;
    end

    // Counts matching samples in DEBOUNCE and all-high samples in RELEASE; saturates at the limit.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stab_cnt <= '0;
        end else if (sample) begin
            unique case (state)
                SCAN:     stab_cnt <= '0;
                DEBOUNCE: if (match && stab_cnt != DEB_LAST) stab_cnt <= stab_cnt + 1'b1;
                PRESSED:  stab_cnt <= any_low ? '0 : DW'(1);
                RELEASE:  if (any_low) stab_cnt <= '0;
                          else if (stab_cnt != DEB_LAST) stab_cnt <= stab_cnt + 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            col_q        <= 2'd0;
            pat_q        <= 4'hF;
            row_q        <= 2'd0;
            teclado_q    <= 4'h0;
            key_detect_q <= 1'b0;
        end else begin
            key_detect_q <= pulse;
            if (advance) col_q <= col_q + 1'b1;
            if (capture) begin
                pat_q <= filas_s;
                row_q <= low_row(filas_s);
            end
            if (accept) teclado_q <= key_code(row_q, col_q);
        end
    end

`ifdef TECLADO_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_SAMPLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SAMPLES - 1);
    logic [RW-1:0] rep_cnt;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rep_cnt <= '0;
        end else if (sample) begin
            if (state != PRESSED || !any_low || rep_cnt == REP_LAST) rep_cnt <= '0;
            else                                                   rep_cnt <= rep_cnt + 1'b1;
        end
    end

    assign repeat_hit = sample && (state == PRESSED) && any_low && (rep_cnt == REP_LAST);
`else
    assign repeat_hit = 1'b0;
`endif

    assign bus.columnas_o   = ~(4'b0001 << col_q);
    assign bus.teclado_o    = teclado_q;
    assign bus.key_detect_o = key_detect_q;
endmodule

// File: tb/tb_teclado_scanner.sv
// Randomized bench for teclado_scanner: emulated 4x4 keypad, transaction-level reference model.
module tb_teclado_scanner;
    localparam int T = 4;
    localparam int D = 3;
    localparam int R = 5;
    localparam int LAT_MAX = (4 + D) * T + 3;
`ifdef TECLADO_AUTOREPEAT_EN
    localparam int AR = 1;
`else
    localparam int AR = 0;
`endif

    logic clk_i = 1'b0;
    logic reset_i = 1'b0;
    always #5 clk_i = ~clk_i;

    teclado_scanner_if bus ();

    teclado_scanner #(.SCAN_TICKS(T), .DEBOUNCE_SAMPLES(D), .REPEAT_SAMPLES(R)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    logic [15:0] keys;          // bit row*4+col set = key held down
    logic [3:0]  rows;
    logic [3:0]  keymap [16];
    logic [3:0]  model_code;
    logic [3:0]  codes [$];
    int          pulse_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !bus.columnas_o[c]) rows[r] = 1'b0;
    end
    assign bus.filas_i = rows;

    always @(posedge clk_i) begin
        #1;
        if (bus.key_detect_o === 1'b1) begin
            pulse_cnt = pulse_cnt + 1;
            codes.push_back(bus.teclado_o);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    function automatic logic [3:0] col_pat(input int c);
        return ~(4'b0001 << c);
    endfunction

    task automatic wait_pulse(input int base, input int limit, output int lat);
        lat = 0;
        while (pulse_cnt == base && lat < limit) begin
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic wait_col(input int c);
        int n;
        n = 0;
        while (bus.columnas_o == col_pat(c) && n < 8*T) begin @(negedge clk_i); n++; end
        while (bus.columnas_o != col_pat(c) && n < 16*T) begin @(negedge clk_i); n++; end
        chk("col_reached", (bus.columnas_o == col_pat(c)) ? 1 : 0, 1);
    endtask

    // exp_rep < 0 skips the pulse-count check (long holds under auto-repeat).
    task automatic do_press(input logic [15:0] mask, input int col, input logic [3:0] exp,
                            input int hold, input bit hold_total, input bit bounce,
                            input int exp_rep);
        int base, lat, bad, h;
        base = pulse_cnt;
        keys = mask;
        wait_pulse(base, LAT_MAX + 2, lat);
        chk("press_latency", (pulse_cnt != base && lat <= LAT_MAX) ? 1 : 0, 1);
        chk("press_code", bus.teclado_o, exp);
        h = hold_total ? hold - lat : hold;
        bad = 0;
        for (int i = 0; i < h; i++) begin
            @(negedge clk_i);
            if (bus.columnas_o !== col_pat(col)) bad++;
        end
        chk("col_frozen", bad, 0);
        keys = '0;
        if (bounce) begin
            cycles(T + 3);
            keys = mask;
            cycles(T);
            keys = '0;
        end
        cycles(30);
        if (exp_rep >= 0) chk("pulse_count", pulse_cnt - base, 1 + exp_rep);
        model_code = exp;
    endtask

    task automatic do_glitch(input logic [15:0] mask, input int len);
        int base;
        logic [3:0] prev_col;
        base = pulse_cnt;
        keys = mask;
        cycles(len);
        keys = '0;
        cycles(30);
        chk("glitch_no_pulse", pulse_cnt - base, 0);
        chk("glitch_keeps_code", bus.teclado_o, model_code);
        prev_col = bus.columnas_o;
        cycles(2*T);
        chk("scan_resumes", (bus.columnas_o != prev_col) ? 1 : 0, 1);
    endtask

    initial begin
        int base, n0;
        keymap = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                   4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
        keys = '0;
        model_code = 4'h0;
        reset_i = 1'b0;
        cycles(3);
        chk("rst_columnas", bus.columnas_o, 4'b1110);
        chk("rst_teclado", bus.teclado_o, 4'h0);
        chk("rst_detect", bus.key_detect_o, 0);
        reset_i = 1'b1;
        cycles(5);

        // '6' held ~200 cycles
        do_press(16'h0040, 2, 4'h6, 200, 1'b1, 1'b0, AR ? -1 : 0);

        // two-sample glitch on '1'
        wait_col(0);
        do_glitch(16'h0001, 7);

        // rows 1 and 2 on column 0: lowest row wins
        do_press(16'h0110, 0, 4'h4, 10, 1'b0, 1'b0, 0);

        // '#' with a bounce during release, then '*'
        base = pulse_cnt;
        n0 = codes.size();
        do_press(16'h4000, 2, 4'hF, 10, 1'b0, 1'b1, 0);
        do_press(16'h1000, 0, 4'hE, 10, 1'b0, 1'b0, 0);
        chk("hash_star_pulses", pulse_cnt - base, 2);
        chk("hash_code", codes[n0], 4'hF);
        chk("star_code", codes[n0+1], 4'hE);

        // 'A' held for three repeat periods after acceptance
        do_press(16'h0008, 3, 4'hA, 70, 1'b0, 1'b0, AR ? 3 : 0);

        // reset in the middle of debouncing '5'
        base = pulse_cnt;
        wait_col(1);
        keys = 16'h0020;
        cycles(11);
        reset_i = 1'b0;
        cycles(2);
        chk("midrst_columnas", bus.columnas_o, 4'b1110);
        chk("midrst_teclado", bus.teclado_o, 4'h0);
        chk("midrst_detect", bus.key_detect_o, 0);
        keys = '0;
        cycles(2);
        reset_i = 1'b1;
        model_code = 4'h0;
        cycles(4);
        chk("midrst_no_pulse", pulse_cnt - base, 0);
        do_press(16'h0020, 1, 4'h5, 10, 1'b0, 1'b0, 0);

        for (int i = 0; i < 12; i++) begin
            int kind, key, col, r1, r2;
            kind = $urandom_range(0, 2);
            key  = $urandom_range(0, 15);
            col  = $urandom_range(0, 3);
            r1   = $urandom_range(0, 2);
            r2   = $urandom_range(r1 + 1, 3);
            case (kind)
                0: do_press(16'(1) << key, key % 4, keymap[key],
                            $urandom_range(4, 14), 1'b0, 1'b0, 0);
                1: do_glitch(16'(1) << key, $urandom_range(1, 8));
                default: do_press((16'(1) << (r1*4 + col)) | (16'(1) << (r2*4 + col)), col,
                                  keymap[r1*4 + col], $urandom_range(4, 14), 1'b0, 1'b0, 0);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
